// File: rtl/cam_cfg_pkg.sv
// Shared types and helpers for the camera register-configuration sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cam_cfg_pkg;

    // Sequencer states, walked once per step enable
    typedef enum logic [2:0] {
        IDLE,
        SEL,
        FETCH,
        XFER,
        WAIT,
        NEXT
    } cfg_state_e;

    // Table register-address values with special meaning
    localparam logic [15:0] TBL_END = 16'hFFFF;
    localparam logic [15:0] TBL_DLY = 16'hFFFE;

    // Delay counter width; 255 ms at any sane step rate fits comfortably
    localparam int DLY_W = 24;

    // Convert a table delay in milliseconds into a number of step ticks.
    // A step rate below 1 kHz is rounded up to one step per millisecond.
    function automatic logic [DLY_W-1:0] ms_to_steps(input logic [7:0] ms,
                                                     input int unsigned step_hz);
        int unsigned per_ms;
        per_ms = step_hz / 1000;
        if (per_ms == 0) begin
            per_ms = 1;
        end
        return DLY_W'(32'(ms) * per_ms);
    endfunction

endpackage

// File: rtl/cam_tick_div.sv
// Step divider: free-running count 0..DIV-1, toggles tick_o and pulses step_en_o at the wrap.
// Latency: step_en_o is a decode of the count register, high for one cycle every DIV cycles.
// Backpressure: none; free-running from reset release.
module cam_tick_div #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o,
    output logic step_en_o
);
    localparam int unsigned     DIV_C    = (DIV < 1) ? 1 : DIV;
    localparam int              CNT_W    = (DIV_C > 1) ? $clog2(DIV_C) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_C - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;

    assign step_en_o = (cnt_q == CNT_LAST);
    assign tick_o    = tick_q;

    // Count up, wrap at DIV-1 and flip the tick on every wrap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (step_en_o) begin
            cnt_q  <= '0;
            tick_q <= ~tick_q;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cam_reg_seq.sv
// Camera register sequencer: walks a {addr16,data8} table and writes it to each masked channel in turn.
// Latency: one write = 1 FETCH step + master time + 1 step; table delays cost max(1, ms*steps_per_ms) steps.
// Backpressure: waits on i2c_tr_end per write; cfg_start ignored while busy. Macro CAM_REG_SEQ_RETRY_EN adds NACK retries.
module cam_reg_seq
    import cam_cfg_pkg::*;
#(
    parameter int          N_CH      = 2,
    parameter int          TBL_DEPTH = 512,
    parameter logic [7:0]  DEV_ADDR  = 8'h78,
    parameter int unsigned CLK_HZ    = 25_000_000,
    parameter int unsigned I2C_HZ    = 20_000,
    parameter int unsigned MAX_RETRY = 3,
    localparam int         IDX_W     = $clog2(TBL_DEPTH),
    localparam int         CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_25M,
    input  logic             camera_rstn,
    input  logic             cfg_start,
    input  logic [N_CH-1:0]  ch_mask,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [23:0]      tbl_data,
    output logic [CH_W-1:0]  i2c_ch,
    output logic [31:0]      i2c_data,
    output logic             i2c_start,
    input  logic             i2c_tr_end,
    input  logic             i2c_nack,
    output logic             i2c_tick,
    output logic             cfg_busy,
    output logic [N_CH-1:0]  cfg_done,
    output logic [N_CH-1:0]  cfg_err
);
    localparam int unsigned      STEP_HZ  = 2 * I2C_HZ;
    localparam int unsigned      DIV      = CLK_HZ / STEP_HZ;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TBL_DEPTH - 1);

    // Retries allowed per entry; zero means the first NACK aborts the channel
`ifdef CAM_REG_SEQ_RETRY_EN
    localparam int unsigned RTY_LIMIT = MAX_RETRY;
`else
    localparam int unsigned RTY_LIMIT = 0;
`endif
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic             step_en;
    cfg_state_e       state_q;
    logic [N_CH-1:0]  mask_q;
    logic [N_CH-1:0]  mask_d;
    logic [CH_W-1:0]  ch_q;
    logic [CH_W-1:0]  sel_ch_d;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      data_q;
    logic             start_q;
    logic             busy_q;
    logic [N_CH-1:0]  done_q;
    logic [N_CH-1:0]  err_q;
    logic [DLY_W-1:0] dly_q;
    logic [RTY_W-1:0] rty_q;
    logic [15:0]      tbl_reg;
    logic [7:0]       tbl_val;

    cam_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk_i     (clk_25M),
        .rst_ni    (camera_rstn),
        .tick_o    (i2c_tick),
        .step_en_o (step_en)
    );

    assign tbl_reg = tbl_data[23:8];
    assign tbl_val = tbl_data[7:0];

    // Lowest channel still pending in the latched mask
    always_comb begin
        sel_ch_d = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel_ch_d = CH_W'(i);
            end
        end
    end

    // Mask with the channel just finished removed
    assign mask_d = mask_q & ~(N_CH'(1) << ch_q);

    // Sequencer FSM: start capture on any cycle, state moves only on step enable
    always_ff @(posedge clk_25M or negedge camera_rstn) begin
        if (!camera_rstn) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            dly_q   <= '0;
            rty_q   <= '0;
        end else begin
            // A start pulse is captured here so a pulse between steps is not lost
            if (state_q == IDLE && !busy_q && cfg_start && (|ch_mask)) begin
                mask_q <= ch_mask;
                done_q <= done_q & ~ch_mask;
                err_q  <= err_q & ~ch_mask;
                busy_q <= 1'b1;
            end
            if (step_en) begin
                case (state_q)
                    IDLE: begin
                        if (busy_q) begin
                            state_q <= SEL;
                        end
                    end
                    SEL: begin
                        ch_q    <= sel_ch_d;
                        idx_q   <= '0;
                        rty_q   <= '0;
                        state_q <= FETCH;
                    end
                    FETCH: begin
                        // The last table slot doubles as an end marker so the index never wraps
                        if (tbl_reg == TBL_END || idx_q == IDX_LAST) begin
                            done_q[ch_q] <= 1'b1;
                            state_q      <= NEXT;
                        end else if (tbl_reg == TBL_DLY) begin
                            dly_q   <= ms_to_steps(tbl_val, STEP_HZ);
                            state_q <= WAIT;
                        end else begin
                            data_q  <= {DEV_ADDR, tbl_data};
                            start_q <= 1'b1;
                            state_q <= XFER;
                        end
                    end
                    XFER: begin
                        if (i2c_tr_end) begin
                            start_q <= 1'b0;
                            if (!i2c_nack) begin
                                idx_q   <= idx_q + IDX_W'(1);
                                rty_q   <= '0;
                                state_q <= FETCH;
                            end else if (rty_q != RTY_W'(RTY_LIMIT)) begin
                                // Re-fetch the same entry; start stays low for that step
                                rty_q   <= rty_q + RTY_W'(1);
                                state_q <= FETCH;
                            end else begin
                                err_q[ch_q] <= 1'b1;
                                state_q     <= NEXT;
                            end
                        end
                    end
                    WAIT: begin
                        // Leaving at count <= 1 makes a delay of N cost N steps, and 0 cost one
                        if (dly_q <= DLY_W'(1)) begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= FETCH;
                        end else begin
                            dly_q <= dly_q - DLY_W'(1);
                        end
                    end
                    NEXT: begin
                        mask_q <= mask_d;
                        if (|mask_d) begin
                            state_q <= SEL;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tbl_index = idx_q;
    assign i2c_ch    = ch_q;
    assign i2c_data  = data_q;
    assign i2c_start = start_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_cam_reg_seq.sv
// Bench for cam_reg_seq: table ROM, byte-master model, directed vector table and corner sequences.
// Latency: master answers three cycles after i2c_start rises.
// Backpressure: master holds tr_end until i2c_start falls.
module tb_cam_reg_seq;
    localparam int N_CH      = 2;
    localparam int TBL_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int CH_W      = 1;

    logic             clk_25M;
    logic             camera_rstn;
    logic             cfg_start;
    logic [N_CH-1:0]  ch_mask;
    logic [IDX_W-1:0] tbl_index;
    logic [23:0]      tbl_data;
    logic [CH_W-1:0]  i2c_ch;
    logic [31:0]      i2c_data;
    logic             i2c_start;
    logic             i2c_tr_end;
    logic             i2c_nack;
    logic             i2c_tick;
    logic             cfg_busy;
    logic [N_CH-1:0]  cfg_done;
    logic [N_CH-1:0]  cfg_err;

    logic [23:0]      rom [TBL_DEPTH];
    assign tbl_data = rom[tbl_index];

    cam_reg_seq #(
        .N_CH      (N_CH),
        .TBL_DEPTH (TBL_DEPTH),
        .DEV_ADDR  (8'h78),
        .CLK_HZ    (4000),
        .I2C_HZ    (1000),
        .MAX_RETRY (3)
    ) dut (
        .clk_25M     (clk_25M),
        .camera_rstn (camera_rstn),
        .cfg_start   (cfg_start),
        .ch_mask     (ch_mask),
        .tbl_index   (tbl_index),
        .tbl_data    (tbl_data),
        .i2c_ch      (i2c_ch),
        .i2c_data    (i2c_data),
        .i2c_start   (i2c_start),
        .i2c_tr_end  (i2c_tr_end),
        .i2c_nack    (i2c_nack),
        .i2c_tick    (i2c_tick),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err)
    );

    int              n_checks;
    int              n_fail;
    int              nack_left;
    logic [31:0]     nack_tgt;
    logic [31:0]     wr_data [$];
    logic [CH_W-1:0] wr_ch [$];
    int              gap_log [$];

    typedef struct {
        logic [1:0]  mask;
        int          nack_n;
        logic [31:0] nack_tgt;
        int          writes;
        logic [7:0]  ch_seq;
        logic [31:0] last;
        logic [1:0]  done;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        clk_25M = 1'b0;
        forever #20 clk_25M = ~clk_25M;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog");
    end

    // Byte master model: answers each request after three cycles, NACKs the planned entry
    initial begin
        int lat;
        i2c_tr_end = 1'b0;
        i2c_nack   = 1'b0;
        lat        = 0;
        forever begin
            @(negedge clk_25M);
            if (i2c_start !== 1'b1) begin
                i2c_tr_end = 1'b0;
                i2c_nack   = 1'b0;
                lat        = 0;
            end else if (!i2c_tr_end) begin
                if (lat == 3) begin
                    wr_data.push_back(i2c_data);
                    wr_ch.push_back(i2c_ch);
                    i2c_nack = 1'b0;
                    if (nack_left > 0 && i2c_data == nack_tgt) begin
                        i2c_nack  = 1'b1;
                        nack_left = nack_left - 1;
                    end
                    i2c_tr_end = 1'b1;
                end else begin
                    lat = lat + 1;
                end
            end
        end
    end

    // Step ticks seen while i2c_start is low, logged at each rising request
    initial begin
        logic ps;
        logic pt;
        int   gap;
        ps  = 1'b0;
        pt  = 1'b0;
        gap = 0;
        forever begin
            @(negedge clk_25M);
            if (ps && i2c_start !== 1'b1) begin
                gap = 0;
            end else if (!ps) begin
                if (i2c_tick !== pt) gap = gap + 1;
                if (i2c_start === 1'b1) gap_log.push_back(gap);
            end
            ps = (i2c_start === 1'b1);
            pt = i2c_tick;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int k);
        if (k >= 0 && k < wr_data.size()) return wr_data[k];
        return 'x;
    endfunction

    function automatic int gap_at(input int k);
        if (k >= 0 && k < gap_log.size()) return gap_log[k];
        return -1;
    endfunction

    task automatic clear_logs();
        wr_data.delete();
        wr_ch.delete();
        gap_log.delete();
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk_25M);
        ch_mask   = m;
        cfg_start = 1'b1;
        @(negedge clk_25M);
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        while (cfg_busy && t < budget) begin
            @(negedge clk_25M);
            t = t + 1;
        end
        if (cfg_busy) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL %s_timeout: cfg_busy still 1 after %0d cycles, required 0", name, budget);
        end
    endtask

    task automatic run_pass(input string name, input logic [1:0] m);
        clear_logs();
        pulse_start(m);
        if (m != 2'b00) begin
            check({name, "_busy_rise"}, 32'(cfg_busy), 32'd1);
            wait_idle(name, 4000);
        end else begin
            repeat (20) @(negedge clk_25M);
        end
    endtask

    task automatic load_table_a();
        for (int i = 0; i < TBL_DEPTH; i++) rom[i] = 24'h0;
        rom[0] = 24'h3103_11;
        rom[1] = 24'h3008_02;
        rom[2] = 24'h3017_42;
        rom[3] = 24'hFFFF_00;
    endtask

    initial begin
        logic [7:0] act_seq;
        logic       t0;
        int         c;
        n_checks    = 0;
        n_fail      = 0;
        nack_left   = 0;
        nack_tgt    = '0;
        camera_rstn = 1'b0;
        cfg_start   = 1'b0;
        ch_mask     = '0;
        load_table_a();

        //            mask   nack target       writes ch_seq last          done   err
        vecs[0] = '{2'b11, 0, 32'h0,         6, 8'h38, 32'h7830_1742, 2'b11, 2'b00};
        vecs[1] = '{2'b01, 0, 32'h0,         3, 8'h00, 32'h7830_1742, 2'b11, 2'b00};
        vecs[2] = '{2'b10, 0, 32'h0,         3, 8'h07, 32'h7830_1742, 2'b11, 2'b00};
`ifdef CAM_REG_SEQ_RETRY_EN
        vecs[3] = '{2'b11, 1, 32'h7830_0802, 7, 8'h70, 32'h7830_1742, 2'b11, 2'b00};
        vecs[4] = '{2'b01, 2, 32'h7830_0802, 5, 8'h00, 32'h7830_1742, 2'b11, 2'b00};
        vecs[5] = '{2'b01, 4, 32'h7830_0802, 5, 8'h00, 32'h7830_0802, 2'b10, 2'b01};
`else
        vecs[3] = '{2'b11, 1, 32'h7830_0802, 5, 8'h1C, 32'h7830_1742, 2'b10, 2'b01};
        vecs[4] = '{2'b10, 1, 32'h7831_0311, 1, 8'h01, 32'h7831_0311, 2'b00, 2'b11};
        vecs[5] = '{2'b11, 0, 32'h0,         6, 8'h38, 32'h7830_1742, 2'b11, 2'b00};
`endif

        // Reset state
        repeat (4) @(negedge clk_25M);
        check("rst_outputs", {i2c_data[27:0], i2c_start, cfg_busy, i2c_tick, i2c_ch}, 32'h0);
        check("rst_status", {24'h0, tbl_index, cfg_done, cfg_err}, 32'h0);
        check("rst_data_hi", {28'h0, i2c_data[31:28]}, 32'h0);
        camera_rstn = 1'b1;

        // Tick half-period equals the divider ratio (2 clocks)
        t0 = i2c_tick;
        c  = 0;
        while (i2c_tick == t0 && c < 50) begin @(negedge clk_25M); c = c + 1; end
        t0 = i2c_tick;
        c  = 0;
        while (i2c_tick == t0 && c < 50) begin @(negedge clk_25M); c = c + 1; end
        check("tick_half_period", 32'(c), 32'd2);

        // Directed vector table
        for (int v = 0; v < 6; v++) begin
            nack_left = vecs[v].nack_n;
            nack_tgt  = vecs[v].nack_tgt;
            run_pass($sformatf("v%0d", v), vecs[v].mask);
            nack_left = 0;
            act_seq   = '0;
            for (int k = 0; k < wr_ch.size() && k < 8; k++) act_seq[k] = wr_ch[k][0];
            check($sformatf("v%0d_writes", v), 32'(wr_data.size()), 32'(vecs[v].writes));
            check($sformatf("v%0d_ch_seq", v), 32'(act_seq), 32'(vecs[v].ch_seq));
            check($sformatf("v%0d_first", v), wr_at(0), 32'h7831_0311);
            check($sformatf("v%0d_last", v), wr_at(wr_data.size() - 1), vecs[v].last);
            check($sformatf("v%0d_done", v), 32'(cfg_done), 32'(vecs[v].done));
            check($sformatf("v%0d_err", v), 32'(cfg_err), 32'(vecs[v].err));
        end

        // Zero mask: nothing happens, status keeps the last vector's values
        run_pass("mask0", 2'b00);
        check("mask0_writes", 32'(wr_data.size()), 32'd0);
        check("mask0_busy", 32'(cfg_busy), 32'd0);
        check("mask0_status", {28'h0, cfg_done, cfg_err}, {28'h0, vecs[5].done, vecs[5].err});

        // Start while busy is ignored: only channel 0 runs, channel 1 status untouched
        clear_logs();
        pulse_start(2'b01);
        repeat (8) @(negedge clk_25M);
        pulse_start(2'b10);
        wait_idle("busy_ign", 4000);
        act_seq = '0;
        for (int k = 0; k < wr_ch.size() && k < 8; k++) act_seq[k] = wr_ch[k][0];
        check("busy_ign_writes", 32'(wr_data.size()), 32'd3);
        check("busy_ign_ch_seq", 32'(act_seq), 32'h0);
        check("busy_ign_done", 32'(cfg_done), 32'h3);
        check("busy_ign_err", 32'(cfg_err), 32'h0);

        // Embedded 5 ms delay: 10 WAIT steps plus the two FETCH steps around it
        for (int i = 0; i < TBL_DEPTH; i++) rom[i] = 24'h0;
        rom[0] = 24'h3103_11;
        rom[1] = 24'h3008_02;
        rom[2] = 24'hFFFE_05;
        rom[3] = 24'h3017_42;
        rom[4] = 24'hFFFF_00;
        run_pass("dly", 2'b01);
        check("dly_writes", 32'(wr_data.size()), 32'd3);
        check("dly_gap_plain", 32'(gap_at(1)), 32'd1);
        check("dly_gap_delay", 32'(gap_at(2)), 32'd12);
        check("dly_after_data", wr_at(2), 32'h7830_1742);

        // No end marker: the last table slot ends the channel
        for (int i = 0; i < TBL_DEPTH; i++) rom[i] = {16'h4000, 8'(i)};
        run_pass("last_idx", 2'b01);
        check("last_idx_writes", 32'(wr_data.size()), 32'd15);
        check("last_idx_data", wr_at(14), 32'h7840_000E);
        check("last_idx_status", {28'h0, cfg_done, cfg_err}, {28'h0, 2'b11, 2'b00});

        // Reset in the middle of a transfer, then a fresh pass from index 0
        load_table_a();
        clear_logs();
        pulse_start(2'b11);
        c = 0;
        while (i2c_start !== 1'b1 && c < 200) begin @(negedge clk_25M); c = c + 1; end
        check("mid_rst_req_seen", 32'(i2c_start), 32'd1);
        @(negedge clk_25M);
        camera_rstn = 1'b0;
        #1;
        check("mid_rst_start", 32'(i2c_start), 32'd0);
        check("mid_rst_outputs", {26'h0, cfg_busy, i2c_tick, i2c_ch, cfg_done},
              32'h0);
        check("mid_rst_regs", {20'h0, tbl_index, cfg_err, 6'h0}, 32'h0);
        check("mid_rst_data", i2c_data, 32'h0);
        repeat (3) @(negedge clk_25M);
        camera_rstn = 1'b1;
        run_pass("post_rst", 2'b01);
        check("post_rst_writes", 32'(wr_data.size()), 32'd3);
        check("post_rst_first", wr_at(0), 32'h7831_0311);
        check("post_rst_status", {28'h0, cfg_done, cfg_err}, {28'h0, 2'b01, 2'b00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
